data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder_if.sv | 23 ++
 rtl/data_memory_responder.sv | 168 ++++++++++++++++
 tb/tb_data_memory_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// Load/store request/response bundle between the memory stage (master)
// and the data memory responder (slave).
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_addr, req_write, req_funct3, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_funct3, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// Memory-stage load/store responder: one request at a time, programmable wait
// states, byte/half/word access on a word-organised RAM built from byte lanes.

module data_memory_responder_lane #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wbyte,
  output logic [7:0]    rbyte
);
  logic [7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wbyte;

  assign rbyte = mem[idx];
endmodule

module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  data_memory_responder_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  req_t        req_q, req_in, req_cur;
  logic        err, bad_f, misal, oob, commit, wr_commit;
  logic [1:0]  size, lane;
  logic [AW-1:0] idx;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, rdata_q;
  logic        err_q;

  assign req_in = '{addr: bus.req_addr, write: bus.req_write,
                    funct3: bus.req_funct3, wdata: bus.req_wdata};

  // At accept (and with zero wait states, at commit) the request comes straight off the bus.
  assign req_cur = (state == IDLE) ? req_in : req_q;
  assign size    = req_cur.funct3[1:0];
  assign lane    = req_cur.addr[1:0];
  assign idx     = req_cur.addr[AW+1:2];

  always_comb begin
    if (req_cur.write)
      bad_f = req_cur.funct3[2] | (size == 2'b11);
    else
      bad_f = (req_cur.funct3 == 3'b011) | (req_cur.funct3 == 3'b110) |
              (req_cur.funct3 == 3'b111);
  end

  assign misal = ((size == 2'b01) & req_cur.addr[0]) |
                 ((size == 2'b10) & (req_cur.addr[1:0] != 2'b00));
  assign oob   = |req_cur.addr[31:AW+2];
  assign err   = bad_f | misal | oob;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (bus.req_valid) state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt == LAST) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stores commit and loads capture on the edge that enters RESP, so a reset
  // anywhere before that edge drops the request without touching the RAM.
  assign commit    = (state_nxt == RESP);
  assign wr_commit = commit & req_cur.write & ~err;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic             be;
    logic [VEC_W-1:0] wb;

    always_comb begin
      be = 1'b0;
      wb = req_cur.wdata[VEC_W*g +: VEC_W];
      case (size)
        2'b00: begin
          be = (lane == 2'(g));
          wb = req_cur.wdata[7:0];
        end
        2'b01: begin
          be = (req_cur.addr[1] == 1'(g / 2));
          wb = req_cur.wdata[VEC_W*(g%2) +: VEC_W];
        end
        2'b10:   be = 1'b1;
        default: be = 1'b0;
      endcase
    end

    data_memory_responder_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (wr_commit & be),
      .idx   (idx),
      .wbyte (wb),
      .rbyte (rd_lanes[g])
    );
  end

  assign ld_byte = rd_lanes[lane];
  assign ld_half = req_cur.addr[1] ? rd_lanes[3:2] : rd_lanes[1:0];

  always_comb begin
    case (req_cur.funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = rd_lanes;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      if (state == IDLE && bus.req_valid) req_q <= req_in;
      rdata_q <= (commit & ~req_cur.write & ~err) ? ld_data : 32'd0;
      err_q   <= commit & err;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = err_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: three responders (1, 0 and 3 wait states) driven one at a
// time; a negedge monitor pops expected responses and checks data and latency.
module tb_data_memory_responder;
  localparam int NDUT = 3;
  localparam int WST [NDUT] = '{1, 0, 3};
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        vld [NDUT];
  logic [31:0] addr, wdata;
  logic        write;
  logic [2:0]  funct3;
  logic        rdy [NDUT];
  logic        rsp_v [NDUT];
  logic [31:0] rsp_rd [NDUT];
  logic        rsp_er [NDUT];

  data_memory_responder_if bus_if [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign bus_if[g].req_valid  = vld[g];
    assign bus_if[g].req_addr   = addr;
    assign bus_if[g].req_write  = write;
    assign bus_if[g].req_funct3 = funct3;
    assign bus_if[g].req_wdata  = wdata;
    assign rdy[g]    = bus_if[g].req_ready;
    assign rsp_v[g]  = bus_if[g].resp_valid;
    assign rsp_rd[g] = bus_if[g].resp_rdata;
    assign rsp_er[g] = bus_if[g].resp_error;

    data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WST[g])) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if[g])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          acc;
  } exp_t;

  exp_t exp_q [$];
  exp_t e;
  int   act = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] m [256];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < NDUT; d++)
        if (d != act) chk("stray_resp", 32'(rsp_v[d]), 32'd0);
      if (rsp_v[act]) begin
        chk("queue_depth_at_resp", 32'(exp_q.size()), 32'd1);
        chk("ready_in_resp", 32'(rdy[act]), 32'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_rdata", rsp_rd[act], e.rd);
          chk("resp_error", 32'(rsp_er[act]), 32'(e.er));
          chk("latency", 32'(cyc - e.acc), 32'(WST[act]));
        end
      end else begin
        chk("rdata_outside_resp", rsp_rd[act], 32'd0);
        if (exp_q.size() != 0) chk("ready_while_busy", 32'(rdy[act]), 32'd0);
      end
    end
  end

  // Entered with valid possibly still high from the previous request; the
  // responder is not in IDLE then, so nothing is re-accepted.
  task automatic do_req(input int d, input bit wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_er, input int gap);
    int t;
    exp_t x;
    @(negedge clk);
    if (gap > 0) begin
      vld[d] = 1'b0;
      repeat (gap) @(negedge clk);
    end
    write = wr; funct3 = f; addr = a; wdata = wd; vld[d] = 1'b1;
    t = 0;
    while (!rdy[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[d]) begin
      chk("ready_timeout", 32'(rdy[d]), 32'd1);
      vld[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    x.rd = exp_rd; x.er = exp_er; x.acc = cyc;
    exp_q.push_back(x);
  endtask

  task automatic drain(input int d);
    int t = 0;
    @(negedge clk);
    vld[d] = 1'b0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_req;
    bit          wr;
    int          sz, o;
    logic [2:0]  f;
    logic [31:0] a, wd, rd;
    wr = 1'($urandom_range(0, 1));
    sz = $urandom_range(0, 2);
    o  = int'($urandom_range(0, 255)) & ~((1 << sz) - 1);
    a  = 32'h100 + 32'(o);
    wd = $urandom;
    f  = 3'(sz);
    rd = 32'd0;
    if (wr) begin
      m[o] = wd[7:0];
      if (sz >= 1) m[o+1] = wd[15:8];
      if (sz == 2) begin m[o+2] = wd[23:16]; m[o+3] = wd[31:24]; end
    end else begin
      if (sz < 2 && $urandom_range(0, 1) == 1) f = f | 3'b100;
      case (f)
        F_B:     rd = {{24{m[o][7]}}, m[o]};
        F_BU:    rd = {24'd0, m[o]};
        F_H:     rd = {{16{m[o+1][7]}}, m[o+1], m[o]};
        F_HU:    rd = {16'd0, m[o+1], m[o]};
        default: rd = {m[o+3], m[o+2], m[o+1], m[o]};
      endcase
    end
    do_req(0, wr, f, a, wd, rd, 1'b0, $urandom_range(0, 3));
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) vld[d] = 1'b0;
    addr = 32'd0; wdata = 32'd0; write = 1'b0; funct3 = 3'd0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_ready", 32'(rdy[d]), 32'd1);
      chk("reset_valid", 32'(rsp_v[d]), 32'd0);
      chk("reset_rdata", rsp_rd[d], 32'd0);
      chk("reset_error", 32'(rsp_er[d]), 32'd0);
    end
    rst = 1'b0;

    // One wait state: word, byte/half lanes, extension and faults.
    act = 0;
    do_req(0, 1, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
    do_req(0, 0, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 0);
    do_req(0, 1, F_B,  32'h13, 32'h00000080, 32'h0,        0, 2);
    do_req(0, 0, F_W,  32'h10, 32'h0,        32'h80ADBEEF, 0, 0);
    do_req(0, 0, F_B,  32'h13, 32'h0,        32'hFFFFFF80, 0, 0);
    do_req(0, 0, F_BU, 32'h13, 32'h0,        32'h00000080, 0, 1);
    do_req(0, 0, F_H,  32'h12, 32'h0,        32'hFFFF80AD, 0, 0);
    do_req(0, 0, F_HU, 32'h10, 32'h0,        32'h0000BEEF, 0, 0);
    do_req(0, 1, F_W,  32'h20, 32'h11223344, 32'h0,        0, 0);
    do_req(0, 0, F_W,  32'h11, 32'h0,        32'h0,        1, 0);
    do_req(0, 1, F_H,  32'h21, 32'hFFFFFFFF, 32'h0,        1, 0);
    do_req(0, 0, F_B,  32'h1000, 32'h0,      32'h0,        1, 1);
    do_req(0, 0, 3'b011, 32'h20, 32'h0,      32'h0,        1, 0);
    do_req(0, 1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0,      1, 0);
    do_req(0, 0, F_W,  32'h20, 32'h0,        32'h11223344, 0, 0);
    drain(0);

    // Zero wait states, valid held high across back-to-back requests.
    act = 1;
    do_req(1, 1, F_W,  32'h0, 32'hA5A5A5A5, 32'h0,        0, 0);
    do_req(1, 0, F_W,  32'h0, 32'h0,        32'hA5A5A5A5, 0, 0);
    do_req(1, 1, F_H,  32'h2, 32'h00007F01, 32'h0,        0, 0);
    do_req(1, 0, F_W,  32'h0, 32'h0,        32'h7F01A5A5, 0, 0);
    do_req(1, 0, F_BU, 32'h1, 32'h0,        32'h000000A5, 0, 0);
    drain(1);

    // Three wait states, then a reset in WAIT that must abandon a store.
    act = 2;
    do_req(2, 1, F_W,  32'h8,  32'h01020304, 32'h0,        0, 0);
    do_req(2, 0, F_H,  32'hA,  32'h0,        32'h00000102, 0, 0);
    do_req(2, 0, F_B,  32'h8,  32'h0,        32'h00000004, 0, 0);
    do_req(2, 1, F_W,  32'h40, 32'hCAFEF00D, 32'h0,        0, 0);
    drain(2);
    @(negedge clk);
    write = 1'b1; funct3 = F_W; addr = 32'h40; wdata = 32'h12345678; vld[2] = 1'b1;
    chk("ready_before_abort", 32'(rdy[2]), 32'd1);
    @(posedge clk);
    #1 vld[2] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_ready", 32'(rdy[2]), 32'd1);
    chk("async_reset_valid", 32'(rsp_v[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    do_req(2, 0, F_W, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0);
    drain(2);

    // Random traffic against a byte model on a freshly written region.
    act = 0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] wd;
      wd = $urandom;
      {m[4*i+3], m[4*i+2], m[4*i+1], m[4*i]} = wd;
      do_req(0, 1, F_W, 32'h100 + 32'(4*i), wd, 32'h0, 0, 0);
    end
    for (int i = 0; i < 200; i++) rand_req();
    drain(0);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
